// File: rtl/traffic_display_if.sv
// Signal bundle between the traffic-light FSM side and the display/monitor block.
// The master drives counter, state and lamps. The slave returns the display and fault outputs.
interface traffic_display_if;
  logic [2:0] counter;
  logic [1:0] traffic_state;
  logic       H_R, H_Y, H_G;
  logic       C_R, C_Y, C_G;
  logic [6:0] seg;
  logic [1:0] an;
  logic       blink_on;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output counter, traffic_state, H_R, H_Y, H_G, C_R, C_Y, C_G,
    input  seg, an, blink_on, fault, fault_code
  );

  modport slave (
    input  counter, traffic_state, H_R, H_Y, H_G, C_R, C_Y, C_G,
    output seg, an, blink_on, fault, fault_code
  );
endinterface

// File: rtl/traffic_display_ctrl.sv
// Two-digit multiplexed 7-segment driver for the traffic-light FSM, with yellow-phase blink
// and a filtered, sticky lamp-conflict monitor that takes over the display once tripped.
module traffic_display_ctrl #(
  parameter int REFRESH_DIV = 4,
  parameter int BLINK_DIV   = 8,
  parameter int FAULT_FILT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  traffic_display_if.slave  bus
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int FW = $clog2(FAULT_FILT + 1);

  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FAULT_FILT);
  localparam logic [6:0]    GLYPH_F  = 7'h71;

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          dsel_q, dsel_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          blink_q, blink_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fault_q, fault_d;
  logic [2:0]    fault_code_q, fault_code_d;
  logic [1:0]    prev_state_q;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  logic [5:0]    lamp_vec;
  logic [5:0]    exp_vec;
  logic [2:0]    cause;
  logic          bad;
  logic          ref_wrap;
  logic          state_chg;

  function automatic logic [6:0] glyph(input logic [2:0] v);
    logic [6:0] g;
    case (v)
      3'd0:    g = 7'h3F;
      3'd1:    g = 7'h06;
      3'd2:    g = 7'h5B;
      3'd3:    g = 7'h4F;
      3'd4:    g = 7'h66;
      3'd5:    g = 7'h6D;
      3'd6:    g = 7'h7D;
      default: g = 7'h07;
    endcase
    return g;
  endfunction

  function automatic logic [5:0] expected_lamps(input logic [1:0] st);
    logic [5:0] v;
    case (st)
      2'd0:    v = 6'b100_001;
      2'd1:    v = 6'b010_010;
      2'd2:    v = 6'b001_100;
      default: v = 6'b010_010;
    endcase
    return v;
  endfunction

  always_comb begin
    lamp_vec  = {bus.H_R, bus.H_Y, bus.H_G, bus.C_R, bus.C_Y, bus.C_G};
    exp_vec   = expected_lamps(bus.traffic_state);
    cause[0]  = bus.H_G & bus.C_G;
    cause[1]  = !$onehot(lamp_vec[5:3]) || !$onehot(lamp_vec[2:0]);
    cause[2]  = (lamp_vec != exp_vec);
    bad       = |cause;
    state_chg = (bus.traffic_state != prev_state_q);

    ref_wrap  = (ref_cnt_q == REF_LAST);
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    dsel_d    = dsel_q ^ ref_wrap;

    // Blink only runs in the two yellow states; a state change restarts it visible.
    blk_cnt_d = '0;
    blink_d   = 1'b1;
    if (!state_chg && bus.traffic_state[0]) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d = '0;
        blink_d   = ~blink_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
        blink_d   = blink_q;
      end
    end

    filt_cnt_d = '0;
    if (bad) begin
      filt_cnt_d = (filt_cnt_q == FILT_MAX) ? filt_cnt_q : filt_cnt_q + 1'b1;
    end

    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    if (!fault_q && bad && (filt_cnt_d == FILT_MAX)) begin
      fault_d      = 1'b1;
      fault_code_d = cause;
    end

    // Fault display switches in one edge after fault rises, hence fault_q, not fault_d.
    an_d = dsel_q ? 2'b10 : 2'b01;
    if (fault_q) begin
      seg_d = dsel_q ? GLYPH_F : glyph(fault_code_q);
    end else if (!blink_d) begin
      seg_d = 7'h00;
    end else begin
      seg_d = dsel_q ? glyph({1'b0, bus.traffic_state}) : glyph(bus.counter);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt_q    <= '0;
      dsel_q       <= 1'b0;
      blk_cnt_q    <= '0;
      blink_q      <= 1'b1;
      filt_cnt_q   <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 3'b000;
      prev_state_q <= 2'd0;
      seg_q        <= 7'h00;
      an_q         <= 2'b00;
    end else begin
      ref_cnt_q    <= ref_cnt_d;
      dsel_q       <= dsel_d;
      blk_cnt_q    <= blk_cnt_d;
      blink_q      <= blink_d;
      filt_cnt_q   <= filt_cnt_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      prev_state_q <= bus.traffic_state;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.blink_on   = blink_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;

endmodule
